// File: rtl/pipe_pkg.sv
// Shared widths and forward-select encodings for the EX forwarding stage.
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_REG_W  = 5;

    typedef enum logic [1:0] {
        FWD_IDEX  = 2'b00,
        FWD_EXMEM = 2'b10,
        FWD_MEMWB = 2'b01
    } fwd_sel_e;

endpackage

// File: rtl/fwd_select.sv
// Per-source comparator and priority encoder choosing the forwarding path.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int REG_W = PIPE_REG_W
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] exmemWriteReg,
    input  logic             exmemRegWrite,
    input  logic             exmemMemToReg,
    input  logic [REG_W-1:0] memwbWriteReg,
    input  logic             memwbRegWrite,
    output logic [1:0]       sel,
    output logic             loadMatch
);

    fwd_sel_e sel_e;
    logic     exmem_hit;
    logic     memwb_hit;

    // A load in EX/MEM has no data yet, so it never wins the EX/MEM path.
    assign exmem_hit = exmemRegWrite && (exmemWriteReg != '0) && (exmemWriteReg == src);
    assign memwb_hit = memwbRegWrite && (memwbWriteReg != '0) && (memwbWriteReg == src);

    always_comb begin
        sel_e = FWD_IDEX;
        if (exmem_hit && !exmemMemToReg) begin
            sel_e = FWD_EXMEM;
        end else if (memwb_hit) begin
            sel_e = FWD_MEMWB;
        end
    end

    assign sel       = sel_e;
    assign loadMatch = exmem_hit && exmemMemToReg;

endmodule

// File: rtl/ex_forward_stage.sv
// EX-stage operand forwarding plus the EX/MEM and MEM/WB pipeline registers.
module ex_forward_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int REG_W  = PIPE_REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_W-1:0]  idexRs,
    input  logic [REG_W-1:0]  idexRt,
    input  logic [DATA_W-1:0] idexReadData1,
    input  logic [DATA_W-1:0] idexReadData2,
    input  logic [DATA_W-1:0] idexImm,
    input  logic              idexALUSrc,
    input  logic              idexRegWrite,
    input  logic              idexMemToReg,
    input  logic [REG_W-1:0]  idexWriteReg,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] memReadData,
    output logic [DATA_W-1:0] inOutMuxForwardA,
    output logic [DATA_W-1:0] inOutMuxForwardB,
    output logic [DATA_W-1:0] storeData,
    output logic [1:0]        forwardA,
    output logic [1:0]        forwardB,
    output logic              loadUse,
    output logic [DATA_W-1:0] exmemAluResult,
    output logic [REG_W-1:0]  exmemWriteReg,
    output logic              exmemRegWrite,
    output logic              exmemMemToReg,
    output logic [DATA_W-1:0] memwbWriteData,
    output logic [REG_W-1:0]  memwbWriteReg,
    output logic              memwbRegWrite
);

    logic              load_match_rs;
    logic              load_match_rt;
    logic [DATA_W-1:0] wb_data_next;
    logic [DATA_W-1:0] fwd_rt;

    fwd_select #(.REG_W(REG_W)) u_fwd_rs (
        .src           (idexRs),
        .exmemWriteReg (exmemWriteReg),
        .exmemRegWrite (exmemRegWrite),
        .exmemMemToReg (exmemMemToReg),
        .memwbWriteReg (memwbWriteReg),
        .memwbRegWrite (memwbRegWrite),
        .sel           (forwardA),
        .loadMatch     (load_match_rs)
    );

    fwd_select #(.REG_W(REG_W)) u_fwd_rt (
        .src           (idexRt),
        .exmemWriteReg (exmemWriteReg),
        .exmemRegWrite (exmemRegWrite),
        .exmemMemToReg (exmemMemToReg),
        .memwbWriteReg (memwbWriteReg),
        .memwbRegWrite (memwbRegWrite),
        .sel           (forwardB),
        .loadMatch     (load_match_rt)
    );

    assign loadUse      = load_match_rs | load_match_rt;
    assign wb_data_next = exmemMemToReg ? memReadData : exmemAluResult;

    always_ff @(posedge clk) begin
        if (reset) begin
            exmemAluResult <= '0;
            exmemWriteReg  <= '0;
            exmemRegWrite  <= 1'b0;
            exmemMemToReg  <= 1'b0;
            memwbWriteData <= '0;
            memwbWriteReg  <= '0;
            memwbRegWrite  <= 1'b0;
        end else if (flush) begin
            // Flush overrides stall: bubble into EX/MEM while MEM/WB still drains.
            exmemAluResult <= '0;
            exmemWriteReg  <= '0;
            exmemRegWrite  <= 1'b0;
            exmemMemToReg  <= 1'b0;
            memwbWriteData <= wb_data_next;
            memwbWriteReg  <= exmemWriteReg;
            memwbRegWrite  <= exmemRegWrite;
        end else if (!stall) begin
            exmemAluResult <= aluResult;
            exmemWriteReg  <= idexWriteReg;
            exmemRegWrite  <= idexRegWrite;
            exmemMemToReg  <= idexMemToReg;
            memwbWriteData <= wb_data_next;
            memwbWriteReg  <= exmemWriteReg;
            memwbRegWrite  <= exmemRegWrite;
        end
    end

    always_comb begin
        inOutMuxForwardA = idexReadData1;
        case (forwardA)
            FWD_EXMEM: inOutMuxForwardA = exmemAluResult;
            FWD_MEMWB: inOutMuxForwardA = memwbWriteData;
            default:   inOutMuxForwardA = idexReadData1;
        endcase
    end

    always_comb begin
        fwd_rt = idexReadData2;
        case (forwardB)
            FWD_EXMEM: fwd_rt = exmemAluResult;
            FWD_MEMWB: fwd_rt = memwbWriteData;
            default:   fwd_rt = idexReadData2;
        endcase
    end

    assign storeData        = fwd_rt;
    assign inOutMuxForwardB = idexALUSrc ? idexImm : fwd_rt;

endmodule
